alib_rft_controller: RTL
========================

# alib_rft_controller

Sequencing controller for the ranked frequency table (RFT) block. It owns the table's reset/clear, streams a block of parallel byte lanes into the table, triggers rank calculation when the block closes, then time-shares the table's single rank-query port among several requesters with round-robin arbitration. It sits between the compression front-end's byte stream and the symbol-remap stage.

## Interface
- NUMBER_OF_PARALLEL_INPUTS, 8, byte lanes per beat (must match the table)
- NUM_REQUESTERS, 2, rank-query clients
- MAX_BLOCK_BEATS, 4096, beat limit per block (used only with auto-close)
- BEAT_CNT_BITS, 16, width of the beat counter

Ports (P = NUMBER_OF_PARALLEL_INPUTS, R = NUM_REQUESTERS):
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-low
- i_data  in  8*P  byte lanes, lane n = i_data[8n+:8]
- i_keep  in  P  per-lane byte valid
- i_valid  in  1  beat valid
- i_last  in  1  final beat of block
- o_ready  out  1  beat accepted when i_valid & o_ready
- o_tbl_rst_n  out  1  table reset, active-low
- o_tbl_char  out  8*P  table i_char
- o_tbl_valid  out  P  table i_valid
- o_tbl_start_rank  out  1  table i_start_rank_calc
- i_tbl_ready  in  1  table o_ready
- i_tbl_rank_done  in  1  table o_rank_done
- o_tbl_query_char  out  8  table i_query_char
- i_tbl_query_rank  in  8  table o_query_rank
- i_req  in  R  query request, held until granted
- i_req_char  in  8*R  query character per requester
- o_gnt  out  R  one-hot grant (one cycle)
- o_rsp_valid  out  R  one-hot response strobe
- o_rsp_rank  out  8  rank, valid with o_rsp_valid
- i_flush  in  1  end serving, start next block
- o_state  out  3  current FSM state
- o_beat_cnt  out  BEAT_CNT_BITS  beats accepted in current block

## Operation
- States: CLEAR(0), WAIT_CLR(1), COUNT(2), RANK(3), SERVE(4).
- Reset (i_rst low): state CLEAR, o_beat_cnt 0, arbiter pointer 0, all grants/strobes 0.
- CLEAR: o_tbl_rst_n = 0 for exactly one cycle; o_tbl_rst_n = i_rst elsewhere, so system reset also clears the table. Next WAIT_CLR.
- WAIT_CLR: wait for i_tbl_ready = 1 (table's 256-cycle clear), then COUNT; o_beat_cnt <= 0.
- COUNT: o_ready = i_tbl_ready. On a handshake: o_tbl_char = i_data, o_tbl_valid = i_keep; otherwise o_tbl_valid = 0. o_beat_cnt increments, saturating at all-ones. Handshake with i_last -> RANK. i_keep = 0 beat counts as a beat but updates nothing.
- RANK: o_tbl_start_rank high on the first RANK cycle only; remain until i_tbl_rank_done, then SERVE. o_ready = 0.
- SERVE: round-robin arbiter over i_req; at most one grant per cycle; pointer moves to winner+1 (mod R). Granted char driven on o_tbl_query_char in the grant cycle; o_rsp_valid = grant delayed one cycle, o_rsp_rank = i_tbl_query_rank.
- i_req outside SERVE: no grant, requests stay pending.
- i_flush in SERVE: no grant that cycle; the previous cycle's response is still delivered; next state CLEAR. i_flush ignored in other states.

## Timing
- Table clear: CLEAR 1 cycle + WAIT_CLR ≥ 256 cycles.
- Data path to table combinational (zero latency).
- Query: grant at cycle t, o_rsp_valid/o_rsp_rank at t+1; back-to-back grants every cycle, throughput 1 query/cycle.
- RANK -> SERVE the cycle after i_tbl_rank_done is sampled high.
- Mid-operation reset: next edge forces CLEAR; any in-flight response is dropped (o_rsp_valid 0).

## Configuration
- ALIB_RFT_CTRL_AUTO_CLOSE_EN defined: a handshake making o_beat_cnt == MAX_BLOCK_BEATS closes the block (-> RANK) as if i_last were set; i_last still closes earlier.
- Undefined: only i_last closes a block; counter saturates and blocks may be unbounded.

## Structure
- Package alib_rft_ctrl_pkg: state enum (CLEAR..SERVE), 3-bit state width, default parameter constants.
- Sub-module alib_rr_arbiter (R-way round-robin, one-hot grant, pointer update on grant).

## Test plan
- Reset then idle -> o_tbl_rst_n low 1 cycle, o_state 1 until i_tbl_ready, then 2; o_ready tracks i_tbl_ready.
- Three beats, i_keep 8'hFF, i_last on third -> o_beat_cnt 3, o_tbl_start_rank single-cycle pulse, SERVE after rank_done.
- Both requesters held high, chars 0x41/0x42 -> grants alternate 0,1,0,1; each o_rsp_valid one cycle after grant with model rank.
- i_flush in cycle after a grant -> response still delivered, no new grant, o_state 0 then 1.
- AUTO_CLOSE_EN, MAX_BLOCK_BEATS 4, no i_last -> RANK after 4th beat; undefined -> stays COUNT.
- i_rst low during RANK -> CLEAR, o_beat_cnt 0, no o_rsp_valid.

Source files
------------

// File: rtl/alib_rft_ctrl_pkg.sv
// Shared types and defaults for the ranked frequency table controller.
package alib_rft_ctrl_pkg;

    localparam int STATE_W       = 3;
    localparam int DEF_PAR_IN    = 8;
    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_MAX_BEATS = 4096;
    localparam int DEF_CNT_BITS  = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_CLEAR    = 3'd0,
        ST_WAIT_CLR = 3'd1,
        ST_COUNT    = 3'd2,
        ST_RANK     = 3'd3,
        ST_SERVE    = 3'd4
    } state_t;

endpackage

// File: rtl/alib_rr_arbiter.sv
// R-way round-robin arbiter; one-hot grant, pointer advances past the winner.
module alib_rr_arbiter
    import alib_rft_ctrl_pkg::*;
#(
    parameter int R = DEF_NUM_REQ,
    localparam int IW = (R > 1) ? $clog2(R) : 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [R-1:0] i_req,
    output logic [R-1:0] o_gnt
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] win;
    logic [IW-1:0] cand;
    logic          any;
    int            pos;

    always_comb begin
        o_gnt = '0;
        win   = '0;
        any   = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int i = 0; i < R; i++) begin
            pos = int'(ptr) + i;
            if (pos >= R) pos = pos - R;
            cand = IW'(pos);
            if (i_en && !any && i_req[cand]) begin
                any         = 1'b1;
                win         = cand;
                o_gnt[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            ptr <= '0;
        end else if (any) begin
            ptr <= (win == IW'(R - 1)) ? '0 : win + 1'b1;
        end
    end

endmodule

// File: rtl/alib_rft_controller.sv
// RFT sequencing controller: clear, stream, rank, then arbitrated query serving.
// Optional block auto-close at MAX_BLOCK_BEATS: define ALIB_RFT_CTRL_AUTO_CLOSE_EN.
module alib_rft_controller
    import alib_rft_ctrl_pkg::*;
#(
    parameter int NUMBER_OF_PARALLEL_INPUTS = DEF_PAR_IN,
    parameter int NUM_REQUESTERS            = DEF_NUM_REQ,
    parameter int MAX_BLOCK_BEATS           = DEF_MAX_BEATS,
    parameter int BEAT_CNT_BITS             = DEF_CNT_BITS
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst,
    input  logic [8*NUMBER_OF_PARALLEL_INPUTS-1:0] i_data,
    input  logic [NUMBER_OF_PARALLEL_INPUTS-1:0]   i_keep,
    input  logic                                   i_valid,
    input  logic                                   i_last,
    output logic                                   o_ready,
    output logic                                   o_tbl_rst_n,
    output logic [8*NUMBER_OF_PARALLEL_INPUTS-1:0] o_tbl_char,
    output logic [NUMBER_OF_PARALLEL_INPUTS-1:0]   o_tbl_valid,
    output logic                                   o_tbl_start_rank,
    input  logic                                   i_tbl_ready,
    input  logic                                   i_tbl_rank_done,
    output logic [7:0]                             o_tbl_query_char,
    input  logic [7:0]                             i_tbl_query_rank,
    input  logic [NUM_REQUESTERS-1:0]              i_req,
    input  logic [8*NUM_REQUESTERS-1:0]            i_req_char,
    output logic [NUM_REQUESTERS-1:0]              o_gnt,
    output logic [NUM_REQUESTERS-1:0]              o_rsp_valid,
    output logic [7:0]                             o_rsp_rank,
    input  logic                                   i_flush,
    output logic [STATE_W-1:0]                     o_state,
    output logic [BEAT_CNT_BITS-1:0]               o_beat_cnt
);

    localparam int R = NUM_REQUESTERS;
`ifdef ALIB_RFT_CTRL_AUTO_CLOSE_EN
    localparam logic AUTO_CLOSE = 1'b1;
`else
    localparam logic AUTO_CLOSE = 1'b0;
`endif

    state_t                   state;
    state_t                   state_nxt;
    logic [BEAT_CNT_BITS-1:0] beat_cnt;
    logic [BEAT_CNT_BITS-1:0] cnt_nxt;
    logic [R-1:0]             gnt;
    logic [R-1:0]             rsp_valid;
    logic                     rank_seen;
    logic                     hs;
    logic                     at_max;
    logic                     close;
    logic                     arb_en;

    assign o_ready = (state == ST_COUNT) && i_tbl_ready;
    assign hs      = o_ready && i_valid;
    assign cnt_nxt = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;
    assign at_max  = (cnt_nxt == BEAT_CNT_BITS'(MAX_BLOCK_BEATS));
    assign close   = hs && (i_last || (AUTO_CLOSE && at_max));
    assign arb_en  = (state == ST_SERVE) && !i_flush;

    // Table clear covers both system reset and the one-cycle CLEAR pulse.
    assign o_tbl_rst_n      = i_rst && (state != ST_CLEAR);
    assign o_tbl_char       = i_data;
    assign o_tbl_valid      = hs ? i_keep : '0;
    assign o_tbl_start_rank = (state == ST_RANK) && !rank_seen;
    assign o_gnt            = gnt;
    assign o_rsp_valid      = rsp_valid;
    assign o_rsp_rank       = i_tbl_query_rank;
    assign o_state          = state;
    assign o_beat_cnt       = beat_cnt;

    always_comb begin
        o_tbl_query_char = '0;
        for (int n = 0; n < R; n++) begin
            if (gnt[n]) o_tbl_query_char = i_req_char[8*n +: 8];
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_CLEAR:    state_nxt = ST_WAIT_CLR;
            ST_WAIT_CLR: if (i_tbl_ready) state_nxt = ST_COUNT;
            ST_COUNT:    if (close) state_nxt = ST_RANK;
            ST_RANK:     if (i_tbl_rank_done) state_nxt = ST_SERVE;
            ST_SERVE:    if (i_flush) state_nxt = ST_CLEAR;
            default:     state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state     <= ST_CLEAR;
            beat_cnt  <= '0;
            rank_seen <= 1'b0;
            rsp_valid <= '0;
        end else begin
            state     <= state_nxt;
            rank_seen <= (state == ST_RANK);
            rsp_valid <= gnt;
            if (state == ST_CLEAR || state == ST_WAIT_CLR) begin
                beat_cnt <= '0;
            end else if (hs) begin
                beat_cnt <= cnt_nxt;
            end
        end
    end

    alib_rr_arbiter #(
        .R(R)
    ) u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (arb_en),
        .i_req (i_req),
        .o_gnt (gnt)
    );

endmodule
